// File: rtl/dispense_ctrl.sv
// ============================================================================
// Module   : dispense_ctrl
// Purpose  : Vend sequencer: motor run, drop confirmation with timeout,
//            change or full-refund payout as coin pulses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dispense_ctrl #(
  parameter int PRICE_A        = 2,
  parameter int PRICE_B        = 3,
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vendA,
  input  logic       vendB,
  input  logic [3:0] total,
  input  logic       sensor_caida,
  output logic       motorA,
  output logic       motorB,
  output logic       cambio_pulso,
  output logic [3:0] cambio_pend,
  output logic       busy,
  output logic       entregado,
  output logic       falla
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOTOR     = 3'd1,
    S_WAIT_DROP = 3'd2,
    S_CHANGE_HI = 3'd3,
    S_CHANGE_LO = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // One counter is shared by the motor run and the drop timeout.
  localparam int c_CNT_MAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_MOTOR_LAST   = c_CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [3:0]         c_PRICE_A      = 4'(PRICE_A);
  localparam logic [3:0]         c_PRICE_B      = 4'(PRICE_B);

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_drop_seen;
  logic [3:0]           r_refund;
  logic [3:0]           r_pend;
  logic                 r_motor_a;
  logic                 r_motor_b;
  logic                 r_pulso;
  logic                 r_busy;
  logic                 r_entregado;
  logic                 r_falla;

  logic [3:0]           w_price;
  logic [3:0]           w_change;

  // B wins when both requests arrive together; change saturates at zero.
  assign w_price  = vendB ? c_PRICE_B : c_PRICE_A;
  assign w_change = (total >= w_price) ? (total - w_price) : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_drop_seen <= 1'b0;
      r_refund    <= 4'd0;
      r_pend      <= 4'd0;
      r_motor_a   <= 1'b0;
      r_motor_b   <= 1'b0;
      r_pulso     <= 1'b0;
      r_busy      <= 1'b0;
      r_entregado <= 1'b0;
      r_falla     <= 1'b0;
    end else begin
      r_pulso     <= 1'b0;
      r_entregado <= 1'b0;
      r_falla     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (vendA || vendB) begin
            r_pend      <= w_change;
            r_refund    <= total;
            r_drop_seen <= 1'b0;
            r_cnt       <= '0;
            r_motor_a   <= ~vendB;
            r_motor_b   <= vendB;
            r_busy      <= 1'b1;
            r_state     <= S_MOTOR;
          end
        end

        S_MOTOR: begin
          if (sensor_caida) begin
            r_drop_seen <= 1'b1;
          end
          if (r_cnt == c_MOTOR_LAST) begin
            r_motor_a <= 1'b0;
            r_motor_b <= 1'b0;
            r_cnt     <= '0;
            // A drop in the final motor cycle still counts as seen.
            if (r_drop_seen || sensor_caida) begin
              r_pulso <= (r_pend != 4'd0);
              r_state <= S_CHANGE_HI;
            end else begin
              r_state <= S_WAIT_DROP;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_WAIT_DROP: begin
          if (sensor_caida) begin
            r_pulso <= (r_pend != 4'd0);
            r_state <= S_CHANGE_HI;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_falla <= 1'b1;
            r_pend  <= r_refund;
            r_pulso <= (r_refund != 4'd0);
            r_state <= S_CHANGE_HI;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        S_CHANGE_HI: begin
          if (r_pend == 4'd0) begin
            r_entregado <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_pend  <= r_pend - 4'd1;
            r_state <= S_CHANGE_LO;
          end
        end

        S_CHANGE_LO: begin
          r_pulso <= (r_pend != 4'd0);
          r_state <= S_CHANGE_HI;
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_motor_a <= 1'b0;
          r_motor_b <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign motorA       = r_motor_a;
  assign motorB       = r_motor_b;
  assign cambio_pulso = r_pulso;
  assign cambio_pend  = r_pend;
  assign busy         = r_busy;
  assign entregado    = r_entregado;
  assign falla        = r_falla;

endmodule

`default_nettype wire

// File: tb/tb_dispense_ctrl.sv
// ============================================================================
// Module   : tb_dispense_ctrl
// Purpose  : Directed transaction vectors and reset-abort sequence for
//            dispense_ctrl (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vendA = 1'b0;
  logic       vendB = 1'b0;
  logic [3:0] total = 4'd0;
  logic       sensor_caida = 1'b0;
  logic       motorA;
  logic       motorB;
  logic       cambio_pulso;
  logic [3:0] cambio_pend;
  logic       busy;
  logic       entregado;
  logic       falla;

  int n_vec = 0;
  int n_err = 0;

  dispense_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .vendA        (vendA),
    .vendB        (vendB),
    .total        (total),
    .sensor_caida (sensor_caida),
    .motorA       (motorA),
    .motorB       (motorB),
    .cambio_pulso (cambio_pulso),
    .cambio_pend  (cambio_pend),
    .busy         (busy),
    .entregado    (entregado),
    .falla        (falla)
  );

  always #5 clk = ~clk;

  // Cycle numbers count from 1 = first motor cycle after the request edge.
  typedef struct {
    logic       va;
    logic       vb;
    logic [3:0] tot;
    int         sens_start;
    int         sens_len;
    int         late_va;
    int         exp_mot_a;
    int         exp_mot_b;
    int         exp_pend0;
    int         exp_pulses;
    int         exp_falla;
    int         exp_falla_cyc;
    int         exp_ent_cyc;
    int         exp_busy;
  } vec_t;

  vec_t  vecs[7];
  string names[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  k = 1;
    bit  done = 0;
    int  mot_a = 0, mot_b = 0, pulses = 0, fallas = 0, ents = 0;
    int  busy_n = 0, overlap = 0, pend0 = -1, falla_cyc = -1, ent_cyc = -1;
    int  mot_last = 0, late_busy = 0;
    @(posedge clk); #1;
    vendA = v.va; vendB = v.vb; total = v.tot;
    @(posedge clk); #1;
    vendA = 1'b0; vendB = 1'b0;
    while (!done && k <= 200) begin
      sensor_caida = (v.sens_start != 0) && (k >= v.sens_start) && (k < v.sens_start + v.sens_len);
      vendA = (k == v.late_va);
      if (k == 1) pend0 = cambio_pend;
      if (motorA) begin mot_a++; mot_last = k; end
      if (motorB) begin mot_b++; mot_last = k; end
      if (cambio_pulso) pulses++;
      if (falla) begin fallas++; if (falla_cyc < 0) falla_cyc = k; end
      if (entregado) begin ents++; if (ent_cyc < 0) ent_cyc = k; end
      if (falla && entregado) overlap++;
      if (!busy) done = 1;
      else busy_n++;
      @(posedge clk); #1;
      k++;
    end
    sensor_caida = 1'b0;
    vendA = 1'b0;
    chk({nm, " finished"}, int'(done), 1);
    for (int j = 0; j < 10; j++) begin
      if (busy || motorA || motorB) late_busy++;
      @(posedge clk); #1;
    end
    chk({nm, " motorA cycles"}, mot_a, v.exp_mot_a);
    chk({nm, " motorB cycles"}, mot_b, v.exp_mot_b);
    chk({nm, " motor last cycle"}, mot_last, 8);
    chk({nm, " pend after capture"}, pend0, v.exp_pend0);
    chk({nm, " change pulses"}, pulses, v.exp_pulses);
    chk({nm, " falla pulses"}, fallas, v.exp_falla);
    chk({nm, " falla cycle"}, falla_cyc, v.exp_falla_cyc);
    chk({nm, " entregado pulses"}, ents, 1);
    chk({nm, " entregado cycle"}, ent_cyc, v.exp_ent_cyc);
    chk({nm, " busy cycles"}, busy_n, v.exp_busy);
    chk({nm, " falla/entregado overlap"}, overlap, 0);
    chk({nm, " activity after idle"}, late_busy, 0);
  endtask

  initial begin
    //          va    vb    tot  s_st s_len late motA motB pend0 puls fal fcyc ent busy
    vecs[0] = '{1'b1, 1'b0, 4'd5,  3, 1, 0, 8, 0,  3,  3, 0, -1, 16, 16}; names[0] = "A_drop_in_motor";
    vecs[1] = '{1'b0, 1'b1, 4'd3, 13, 1, 0, 0, 8,  0,  0, 0, -1, 15, 15}; names[1] = "B_drop_in_wait";
    vecs[2] = '{1'b1, 1'b0, 4'd4,  0, 0, 0, 8, 0,  2,  4, 1, 41, 50, 50}; names[2] = "A_timeout_refund";
    vecs[3] = '{1'b1, 1'b1, 4'd6,  2, 1, 4, 0, 8,  3,  3, 0, -1, 16, 16}; names[3] = "AB_priority";
    vecs[4] = '{1'b1, 1'b0, 4'd5, 40, 1, 0, 8, 0,  3,  3, 0, -1, 48, 48}; names[4] = "sensor_at_timeout";
    vecs[5] = '{1'b0, 1'b1, 4'd1,  8, 1, 0, 0, 8,  0,  0, 0, -1, 10, 10}; names[5] = "B_saturate_last_motor";
    vecs[6] = '{1'b1, 1'b0, 4'd15, 9, 1, 0, 8, 0, 13, 13, 0, -1, 37, 37}; names[6] = "A_max_credit";

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({motorA, motorB, cambio_pulso, cambio_pend, busy, entregado, falla}), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle after reset", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], names[i]);
    end

    // Reset during CHANGE_LO with two units still pending.
    @(posedge clk); #1;
    vendA = 1'b1; total = 4'd5;
    @(posedge clk); #1;
    vendA = 1'b0; sensor_caida = 1'b1;
    @(posedge clk); #1;
    sensor_caida = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort CHANGE_HI pulse", int'(cambio_pulso), 1);
    chk("abort CHANGE_HI pend", int'(cambio_pend), 3);
    @(posedge clk); #1;
    chk("abort CHANGE_LO pulse", int'(cambio_pulso), 0);
    chk("abort CHANGE_LO pend", int'(cambio_pend), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort outputs cleared", int'({motorA, motorB, cambio_pulso, cambio_pend, busy, entregado, falla}), 0);
    @(posedge clk); #1;
    chk("abort stays idle", int'({busy, cambio_pulso, entregado}), 0);
    run_vec('{1'b1, 1'b0, 4'd2, 1, 1, 0, 8, 0, 0, 0, 0, -1, 10, 10}, "A_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
